// File: rtl/rvfi_order_serializer.sv
// Reorders per-channel RVFI retire records into a single in-order stream.
// Records land in a slot addressed by their order and drain from next_order.
module rvfi_order_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [64*NRET-1:0]   rvfi_order,
    input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
    input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_order,
    output logic [XLEN-1:0]      out_pc_rdata,
    output logic [XLEN-1:0]      out_pc_wdata,
    output logic [AW:0]          occupancy,
    output logic                 err
);

    logic [DEPTH-1:0] full_q;
    logic [63:0]      ord_q   [DEPTH];
    logic [XLEN-1:0]  rdata_q [DEPTH];
    logic [XLEN-1:0]  wdata_q [DEPTH];
    logic [63:0]      next_q;
    logic             err_q;

    logic [AW-1:0]    head;
    logic             pop;
    logic [AW-1:0]    slot_c [NRET];
    logic [NRET-1:0]  acc;
    logic [NRET-1:0]  drop;

    assign head = next_q[AW-1:0];
    assign pop  = out_valid && out_ready;

    always_comb begin
        logic [63:0] ord;
        logic [63:0] diff;
        logic        inwin;
        logic        conflict;
        acc  = '0;
        drop = '0;
        for (int c = 0; c < NRET; c++) begin
            ord       = rvfi_order[c*64 +: 64];
            slot_c[c] = ord[AW-1:0];
        end
        for (int c = 0; c < NRET; c++) begin
            ord      = rvfi_order[c*64 +: 64];
            diff     = ord - next_q;
            inwin    = (ord >= next_q) && (diff < 64'(DEPTH));
            conflict = 1'b0;
            // lower channels win a shared slot whether or not they are accepted
            for (int j = 0; j < c; j++) begin
                if (rvfi_valid[j] && (slot_c[j] == slot_c[c])) begin
                    conflict = 1'b1;
                end
            end
            acc[c]  = rvfi_valid[c] && inwin && !full_q[slot_c[c]] && !conflict;
            drop[c] = rvfi_valid[c] && !acc[c];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            full_q <= '0;
            next_q <= '0;
            err_q  <= 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                ord_q[s]   <= '0;
                rdata_q[s] <= '0;
                wdata_q[s] <= '0;
            end
        end else begin
            if (pop) begin
                full_q[head] <= 1'b0;
                next_q       <= next_q + 64'd1;
            end
            for (int c = 0; c < NRET; c++) begin
                if (acc[c]) begin
                    full_q[slot_c[c]]  <= 1'b1;
                    ord_q[slot_c[c]]   <= rvfi_order[c*64 +: 64];
                    rdata_q[slot_c[c]] <= rvfi_pc_rdata[c*XLEN +: XLEN];
                    wdata_q[slot_c[c]] <= rvfi_pc_wdata[c*XLEN +: XLEN];
                end
            end
            if (|drop) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int s = 0; s < DEPTH; s++) begin
            occupancy = occupancy + (AW+1)'(full_q[s]);
        end
    end

    assign out_valid    = full_q[head];
    assign out_order    = out_valid ? ord_q[head]   : '0;
    assign out_pc_rdata = out_valid ? rdata_q[head] : '0;
    assign out_pc_wdata = out_valid ? wdata_q[head] : '0;
    assign err          = err_q;

endmodule
